// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Shift-add multiply and restoring divide, one bit per cycle
//               (32 iterations), on operand magnitudes with a sign fix-up at
//               the end. Divide-by-zero and signed overflow complete without
//               iterating. The pipeline is frozen via stallreq while busy.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               md_req          - M-extension op present in EX
//               md_funct3       - 0 MUL .. 7 REMU
//               md_opa/md_opb   - rs1 / rs2 operands
//               flush           - cancel any operation in progress
//               hold            - EX frozen downstream; keep result presented
//               stallreq        - freeze IF..EX while the op is in flight
//               md_done         - md_result valid this cycle
//               md_result       - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            md_req,
   input  logic [2:0]      md_funct3,
   input  logic [XLEN-1:0] md_opa,
   input  logic [XLEN-1:0] md_opb,
   input  logic            flush,
   input  logic            hold,
   output logic            stallreq,
   output logic            md_done,
   output logic [XLEN-1:0] md_result
);

   localparam int c_CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_stallreq;

   logic [c_CNT_W-1:0]  r_cnt;
   logic [2:0]          r_f3;
   logic                r_neg;       // product / quotient must be negated
   logic                r_rem_neg;   // remainder takes the dividend's sign
   logic [XLEN-1:0]     r_opb;       // multiplicand / divisor magnitude
   logic [2*XLEN-1:0]   r_acc;       // mul: {partial, multiplier}; div: {0, dividend->quotient}
   logic [XLEN:0]       r_rem;       // restoring-division partial remainder
   logic [XLEN-1:0]     r_result;

   // ---------------------------------------------------------------------
   // Operand decode (IDLE-cycle view of the inputs)
   // ---------------------------------------------------------------------
   logic            w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
   logic [XLEN-1:0] w_mag_a, w_mag_b;
   logic            w_div0, w_ovf, w_special;
   logic [XLEN-1:0] w_special_res;
   logic            w_accept;

   // MULH, MULHSU, DIV, REM treat opa as signed; MULH, DIV, REM treat opb so.
   assign w_sgn_a = (md_funct3 == 3'd1) | (md_funct3 == 3'd2) |
                    (md_funct3 == 3'd4) | (md_funct3 == 3'd6);
   assign w_sgn_b = (md_funct3 == 3'd1) | (md_funct3 == 3'd4) | (md_funct3 == 3'd6);
   assign w_neg_a = w_sgn_a & md_opa[XLEN-1];
   assign w_neg_b = w_sgn_b & md_opb[XLEN-1];
   // Negating 0x80000000 yields 0x80000000, which is the correct magnitude
   // when read as unsigned.
   assign w_mag_a = w_neg_a ? -md_opa : md_opa;
   assign w_mag_b = w_neg_b ? -md_opb : md_opb;

   assign w_div0 = md_funct3[2] & (md_opb == '0);
   assign w_ovf  = md_funct3[2] & ~md_funct3[0] &
                   (md_opa == {1'b1, {(XLEN-1){1'b0}}}) & (md_opb == '1);
   assign w_special = w_div0 | w_ovf;

   // funct3[1] selects remainder for the divide group.
   always_comb begin
      w_special_res = '0;
      if (w_div0)
         w_special_res = md_funct3[1] ? md_opa : '1;
      else
         w_special_res = md_funct3[1] ? '0 : md_opa;
   end

   assign w_accept = (r_state == S_IDLE) & md_req & ~flush;

   // ---------------------------------------------------------------------
   // One iteration step
   // ---------------------------------------------------------------------
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_mul_acc;
   logic [XLEN:0]     w_div_shift, w_div_diff, w_div_rem;
   logic              w_div_ge;
   logic [XLEN-1:0]   w_div_quo;
   logic              w_last;

   assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
   assign w_mul_acc   = {w_mul_sum, r_acc[XLEN-1:1]};

   assign w_div_shift = {r_rem[XLEN-1:0], r_acc[XLEN-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_opb};
   // Partial remainder is always below the divisor, so a set MSB of the
   // difference can only mean it went negative.
   assign w_div_ge    = ~w_div_diff[XLEN];
   assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift;
   assign w_div_quo   = {r_acc[XLEN-2:0], w_div_ge};

   assign w_last = (r_state == S_BUSY) & (r_cnt == c_CNT_W'(XLEN - 1));

   // Final sign fix-up and result selection on the last step's values.
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo_fin, w_rem_fin, w_final;

   assign w_prod    = r_neg ? -w_mul_acc : w_mul_acc;
   assign w_quo_fin = r_neg ? -w_div_quo : w_div_quo;
   assign w_rem_fin = r_rem_neg ? -w_div_rem[XLEN-1:0] : w_div_rem[XLEN-1:0];

   always_comb begin
      w_final = '0;
      if (!r_f3[2])
         w_final = (r_f3[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
      else
         w_final = r_f3[1] ? w_rem_fin : w_quo_fin;
   end

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stallreq  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (md_req) begin
               w_stallreq  = 1'b1;
               w_state_nxt = w_special ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            w_stallreq = 1'b1;
            if (w_last)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            // The pipeline advances on the DONE->IDLE edge, so the md_req
            // seen here belongs to the same instruction and is ignored.
            if (!hold)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = S_IDLE;
         w_stallreq  = 1'b0;
      end
      if (rst)
         w_stallreq = 1'b0;
   end

   assign stallreq  = w_stallreq;
   assign md_done   = (r_state == S_DONE) & ~flush;
   assign md_result = r_result;

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_f3      <= '0;
         r_neg     <= 1'b0;
         r_rem_neg <= 1'b0;
         r_opb     <= '0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_result  <= '0;
      end else begin
         if (w_accept) begin
            // Same load for both: low half holds multiplier or dividend.
            r_cnt     <= '0;
            r_f3      <= md_funct3;
            r_neg     <= w_neg_a ^ w_neg_b;
            r_rem_neg <= w_neg_a;
            r_opb     <= w_mag_b;
            r_acc     <= {{XLEN{1'b0}}, w_mag_a};
            r_rem     <= '0;
            if (w_special)
               r_result <= w_special_res;
         end
         if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_f3[2]) begin
               r_acc <= w_mul_acc;
            end else begin
               r_acc <= {{XLEN{1'b0}}, w_div_quo};
               r_rem <= w_div_rem;
            end
            if (w_last && !flush)
               r_result <= w_final;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv. Table of directed vectors
//               plus random ops checked through a result scoreboard, and
//               hand-written hold / flush / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        md_req;
   logic [2:0]  md_funct3;
   logic [31:0] md_opa, md_opb;
   logic        flush, hold;
   logic        stallreq, md_done;
   logic [31:0] md_result;

   ex_muldiv #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .md_req    (md_req),
      .md_funct3 (md_funct3),
      .md_opa    (md_opa),
      .md_opb    (md_opb),
      .flush     (flush),
      .hold      (hold),
      .stallreq  (stallreq),
      .md_done   (md_done),
      .md_result (md_result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] last_res;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference behaviour from the ISA definition using native arithmetic.
   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0]        ua, ub, up;
      logic               ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            sp = sa / sb; return sp[31:0];
         end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            sp = sa % sb; return sp[31:0];
         end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   // Issue one op in the current IDLE cycle; wait for md_done, check latency,
   // stall duration and result, optionally hold DONE for hold_cycles.
   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int hold_cycles);
      int          lat, st_cnt;
      bit          seen;
      logic [31:0] exp_v;
      @(negedge clk);
      md_funct3 = f3; md_opa = a; md_opb = b; md_req = 1'b1;
      sb_q.push_back(exp);
      lat = 0; st_cnt = 0; seen = 1'b0;
      #1;
      while (!seen && lat < 60) begin
         if (stallreq) st_cnt++;
         if (md_done) seen = 1'b1;
         else begin
            @(negedge clk); #1;
            // Operands may change once latched; the result must not care.
            md_opa = $urandom; md_opb = $urandom; md_funct3 = 3'($urandom_range(0, 7));
            lat++;
         end
      end
      if (!seen) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
         md_req = 1'b0;
         void'(sb_q.pop_front());
         return;
      end
      exp_v = sb_q.pop_front();
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_stall_cycles"}, 32'(st_cnt), 32'(exp_lat));
      check({name, "_result"}, md_result, exp_v);
      if (hold_cycles > 0) begin
         hold = 1'b1;
         for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk); #1;
            if (i == hold_cycles - 1) hold = 1'b0;
            check({name, "_hold_done"}, {31'd0, md_done}, 32'd1);
            check({name, "_hold_result"}, md_result, exp_v);
         end
      end
      last_res = exp_v;
      md_req = 1'b0;
   endtask

   task automatic idle_check(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
         check({name, "_done_low"}, {31'd0, md_done}, 32'd0);
         check({name, "_stall_low"}, {31'd0, stallreq}, 32'd0);
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ndone;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;

      rst = 1'b1; md_req = 1'b0; md_funct3 = '0; md_opa = '0; md_opb = '0;
      flush = 1'b0; hold = 1'b0; last_res = '0;

      vecs.push_back('{3'd0, 32'd7,          32'd6,          32'd42,          33});
      vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,           33});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,   33});
      vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,   33});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   33});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   33});
      vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,          33});
      vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,           33});
      vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,   33});
      vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,           33});
      vecs.push_back('{3'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   33});
      vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,   33});
      vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,   1});
      vecs.push_back('{3'd6, 32'd5,          32'd0,          32'd5,           1});
      vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1});
      vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           1});

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_stallreq", {31'd0, stallreq}, 32'd0);
      check("reset_done", {31'd0, md_done}, 32'd0);
      check("reset_result", md_result, 32'd0);

      // Directed table, issued back to back (one idle cycle between ops)
      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                vecs[i].exp, vecs[i].lat, 0);
      idle_check("after_table", 2);

      // Hold DONE for three cycles: four cycles of stable done/result, no restart
      run_op("hold_mul", 3'd0, 32'd7, 32'd6, 32'd42, 33, 3);
      idle_check("after_hold", 3);

      // Back-to-back MUL then DIVU
      run_op("b2b_mul", 3'd0, 32'd1234, 32'd5678, 32'd7006652, 33, 0);
      run_op("b2b_divu", 3'd5, 32'd1000, 32'd33, 32'd30, 33, 0);

      // Flush at BUSY counter 10
      @(negedge clk);
      md_funct3 = 3'd5; md_opa = 32'd999; md_opb = 32'd3; md_req = 1'b1;
      #1 check("flush_req_stall", {31'd0, stallreq}, 32'd1);
      repeat (11) @(negedge clk);
      #1 check("flush_busy_stall", {31'd0, stallreq}, 32'd1);
      flush = 1'b1;
      #1 check("flush_same_cycle_stall", {31'd0, stallreq}, 32'd0);
      @(negedge clk);
      flush = 1'b0; md_req = 1'b0;
      #1 check("flush_next_stall", {31'd0, stallreq}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (md_done) ndone++;
      end
      check("flush_no_done", 32'(ndone), 32'd0);
      check("flush_result_kept", md_result, last_res);

      // Reset at BUSY counter 20 (request held high through reset)
      run_op("pre_rst", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0FD5_BDEE, 33, 0);
      @(negedge clk);
      md_funct3 = 3'd0; md_opa = 32'd3; md_opb = 32'd3; md_req = 1'b1;
      repeat (21) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      check("rst_stallreq", {31'd0, stallreq}, 32'd0);
      check("rst_done", {31'd0, md_done}, 32'd0);
      check("rst_result", md_result, 32'd0);
      rst = 1'b0; md_req = 1'b0;
      idle_check("after_rst", 2);

      // Random ops against the ISA model
      for (int i = 0; i < 12; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         if (i == 5) rb = 32'd0;
         run_op($sformatf("rand%0d", i), rf3, ra, rb, ref_md(rf3, ra, rb),
                (rf3[2] && (rb == 0 || (!rf3[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
                   ? 1 : 33, 0);
      end

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
